// File: rtl/bp_be_dcache_pkg.sv
// Shared dcache types: memory kinds, per-kind opcodes and LCE/memory arbiter states.
// The sweep states exist only when BP_BE_DCACHE_INIT_SWEEP_EN is defined.
// Encodings are 2 bits wide so they drop straight onto the mem packet fields.
package bp_be_dcache_pkg;

  typedef enum logic [1:0] {
    e_cache_mem_data = 2'd0,
    e_cache_mem_tag  = 2'd1,
    e_cache_mem_stat = 2'd2
  } bp_cache_mem_kind_e;

  typedef enum logic [1:0] {
    e_cache_data_mem_read           = 2'd0,
    e_cache_data_mem_write          = 2'd1,
    e_cache_data_mem_uncached_write = 2'd2
  } bp_cache_data_mem_opcode_e;

  typedef enum logic [1:0] {
    e_cache_tag_mem_set_clear  = 2'd0,
    e_cache_tag_mem_invalidate = 2'd1,
    e_cache_tag_mem_set_tag    = 2'd2
  } bp_cache_tag_mem_opcode_e;

  typedef enum logic [1:0] {
    e_cache_stat_mem_set_clear   = 2'd0,
    e_cache_stat_mem_clear_dirty = 2'd1
  } bp_cache_stat_mem_opcode_e;

  typedef enum logic [1:0] {
    e_ready      = 2'd0,
    e_locked     = 2'd1
`ifdef BP_BE_DCACHE_INIT_SWEEP_EN
    , e_sweep_tag  = 2'd2
    , e_sweep_stat = 2'd3
`endif
  } bp_be_dcache_arb_state_e;

endpackage

// File: rtl/bp_be_dcache_rr_arb_2.sv
// Two-way round-robin select: one-hot grant among valid requesters.
// Purely combinational; pointer names the requester favoured on a tie.
// No valid inputs gives an all-zero select.
module bp_be_dcache_rr_arb_2 (
  input  logic [1:0] valid_i,
  input  logic       ptr_i,
  output logic [1:0] sel_o
);

  // Single valid wins outright; on a tie the pointer decides.
  always_comb begin
    sel_o = valid_i;
    if (valid_i == 2'b11) begin
      sel_o = ptr_i ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/bp_be_dcache_lce_mem_arbiter.sv
// Arbitrates LCE cmd / data-cmd requests onto the dcache memory port, with optional
// init sweep (BP_BE_DCACHE_INIT_SWEEP_EN) clearing tag and stat memories of every set.
// Zero-latency packet path; a stalled request keeps its grant until accepted.
module bp_be_dcache_lce_mem_arbiter
  import bp_be_dcache_pkg::*;
#(
  parameter  int sets_p      = 64,
  parameter  int ways_p      = 8,
  localparam int index_width = (sets_p > 1) ? $clog2(sets_p) : 1,
  localparam int way_width   = (ways_p > 1) ? $clog2(ways_p) : 1
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [1:0]                  req_v_i,
  input  logic [1:0][1:0]             req_kind_i,
  input  logic [1:0][1:0]             req_opcode_i,
  input  logic [1:0][index_width-1:0] req_index_i,
  input  logic [1:0][way_width-1:0]   req_way_i,
  input  logic [1:0]                  req_lock_i,
  output logic [1:0]                  req_yumi_o,
  output logic                        mem_v_o,
  output logic [1:0]                  mem_kind_o,
  output logic [1:0]                  mem_opcode_o,
  output logic [index_width-1:0]      mem_index_o,
  output logic [way_width-1:0]        mem_way_o,
  input  logic                        mem_ready_i,
  output logic                        init_done_o
);

  bp_be_dcache_arb_state_e state_r;
  logic                    ptr_r;      // 0 favours requester 0 on a tie
  logic                    owner_r;    // lock owner while in e_locked
  logic                    hold_v_r;   // last cycle's grant stalled on mem_ready_i
  logic                    hold_idx_r;
  logic [1:0]              rr_sel;
  logic [1:0]              sel;
  logic                    sel_idx;
`ifdef BP_BE_DCACHE_INIT_SWEEP_EN
  logic [index_width-1:0]  set_cnt_r;
`endif

  bp_be_dcache_rr_arb_2 rr_arb (
    .valid_i (req_v_i),
    .ptr_i   (ptr_r),
    .sel_o   (rr_sel)
  );

  // Choose the granted requester; a stalled grant is kept so the packet cannot change under it.
  always_comb begin
    sel = 2'b00;
    case (state_r)
      e_ready: begin
        if (hold_v_r && req_v_i[hold_idx_r]) begin
          sel = hold_idx_r ? 2'b10 : 2'b01;
        end else begin
          sel = rr_sel;
        end
      end
      e_locked: sel = owner_r ? 2'b10 : 2'b01;
      default:  sel = 2'b00;
    endcase
    if (reset_i) begin
      sel = 2'b00;
    end
    sel_idx    = sel[1];
    req_yumi_o = sel & req_v_i & {2{mem_ready_i}};
  end

  // Drive the memory packet from the sweep counter or from the granted request.
  always_comb begin
    mem_v_o      = 1'b0;
    mem_kind_o   = 2'b00;
    mem_opcode_o = 2'b00;
    mem_index_o  = '0;
    mem_way_o    = '0;
`ifdef BP_BE_DCACHE_INIT_SWEEP_EN
    if (state_r == e_sweep_tag || state_r == e_sweep_stat) begin
      mem_v_o      = ~reset_i;
      mem_kind_o   = (state_r == e_sweep_tag) ? e_cache_mem_tag : e_cache_mem_stat;
      mem_opcode_o = (state_r == e_sweep_tag) ? e_cache_tag_mem_set_clear
                                              : e_cache_stat_mem_set_clear;
      mem_index_o  = set_cnt_r;
    end else
`endif
    if (sel != 2'b00) begin
      mem_v_o      = |(sel & req_v_i);
      mem_kind_o   = req_kind_i[sel_idx];
      mem_opcode_o = req_opcode_i[sel_idx];
      mem_index_o  = req_index_i[sel_idx];
      mem_way_o    = req_way_i[sel_idx];
    end
    init_done_o = ~reset_i & (state_r == e_ready || state_r == e_locked);
  end

  // Arbiter state machine: sweep, round-robin grant, and lock hold.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
`ifdef BP_BE_DCACHE_INIT_SWEEP_EN
      state_r   <= e_sweep_tag;
      set_cnt_r <= '0;
`else
      state_r   <= e_ready;
`endif
      ptr_r      <= 1'b0;
      owner_r    <= 1'b0;
      hold_v_r   <= 1'b0;
      hold_idx_r <= 1'b0;
    end else begin
      hold_v_r <= 1'b0;
      case (state_r)
`ifdef BP_BE_DCACHE_INIT_SWEEP_EN
        e_sweep_tag: begin
          if (mem_ready_i) state_r <= e_sweep_stat;
        end
        e_sweep_stat: begin
          if (mem_ready_i) begin
            if (set_cnt_r == index_width'(sets_p - 1)) begin
              state_r <= e_ready;
            end else begin
              set_cnt_r <= set_cnt_r + 1'b1;
              state_r   <= e_sweep_tag;
            end
          end
        end
`endif
        e_ready: begin
          if (req_yumi_o != 2'b00) begin
            ptr_r <= ~sel_idx;
            if (req_lock_i[sel_idx]) begin
              state_r <= e_locked;
              owner_r <= sel_idx;
            end
          end else if (mem_v_o) begin
            hold_v_r   <= 1'b1;
            hold_idx_r <= sel_idx;
          end
        end
        e_locked: begin
          if (req_yumi_o != 2'b00) begin
            ptr_r <= ~owner_r;
            if (!req_lock_i[owner_r]) state_r <= e_ready;
          end
        end
        default: state_r <= e_ready;
      endcase
    end
  end

  // Kind 2'b11 has no memory behind it.
  assert property (@(posedge clk_i) disable iff (reset_i)
                   !(req_v_i[0] && req_kind_i[0] == 2'b11));
  assert property (@(posedge clk_i) disable iff (reset_i)
                   !(req_v_i[1] && req_kind_i[1] == 2'b11));

endmodule

// File: tb/tb_bp_be_dcache_lce_mem_arbiter.sv
// Directed bench for the dcache LCE/memory arbiter (sets_p=4, ways_p=8).
// Sweep steps run when BP_BE_DCACHE_INIT_SWEEP_EN is defined, else the no-sweep start-up.
// Inputs change 1ns after the rising edge; outputs are checked on the falling edge.
module tb_bp_be_dcache_lce_mem_arbiter;
  import bp_be_dcache_pkg::*;

  logic            clk_i = 1'b0;
  logic            reset_i;
  logic [1:0]      req_v_i;
  logic [1:0][1:0] req_kind_i;
  logic [1:0][1:0] req_opcode_i;
  logic [1:0][1:0] req_index_i;
  logic [1:0][2:0] req_way_i;
  logic [1:0]      req_lock_i;
  logic [1:0]      req_yumi_o;
  logic            mem_v_o;
  logic [1:0]      mem_kind_o;
  logic [1:0]      mem_opcode_o;
  logic [1:0]      mem_index_o;
  logic [2:0]      mem_way_o;
  logic            mem_ready_i;
  logic            init_done_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  bp_be_dcache_lce_mem_arbiter #(.sets_p(4), .ways_p(8)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .req_v_i      (req_v_i),
    .req_kind_i   (req_kind_i),
    .req_opcode_i (req_opcode_i),
    .req_index_i  (req_index_i),
    .req_way_i    (req_way_i),
    .req_lock_i   (req_lock_i),
    .req_yumi_o   (req_yumi_o),
    .mem_v_o      (mem_v_o),
    .mem_kind_o   (mem_kind_o),
    .mem_opcode_o (mem_opcode_o),
    .mem_index_o  (mem_index_o),
    .mem_way_o    (mem_way_o),
    .mem_ready_i  (mem_ready_i),
    .init_done_o  (init_done_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic to_neg();
    @(negedge clk_i);
  endtask

  task automatic to_next();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(input int i, input logic [1:0] k, input logic [1:0] op,
                         input logic [1:0] idx, input logic [2:0] way, input logic lock);
    req_kind_i[i]   = k;
    req_opcode_i[i] = op;
    req_index_i[i]  = idx;
    req_way_i[i]    = way;
    req_lock_i[i]   = lock;
  endtask

  task automatic chk_reset_outputs();
    to_neg();
    chk("rst_mem_v", 32'(mem_v_o), 32'd0);
    chk("rst_yumi", 32'(req_yumi_o), 32'd0);
    chk("rst_init_done", 32'(init_done_o), 32'd0);
    to_next();
  endtask

  // One sweep beat: expected packet plus no yumi and no init_done.
  task automatic sweep_pkt(input logic [1:0] k, input logic [1:0] idx);
    to_neg();
    chk("sweep_v", 32'(mem_v_o), 32'd1);
    chk("sweep_kind", 32'(mem_kind_o), 32'(k));
    chk("sweep_opcode", 32'(mem_opcode_o), 32'd0);
    chk("sweep_index", 32'(mem_index_o), 32'(idx));
    chk("sweep_way", 32'(mem_way_o), 32'd0);
    chk("sweep_yumi", 32'(req_yumi_o), 32'd0);
    chk("sweep_init_done", 32'(init_done_o), 32'd0);
    to_next();
  endtask

  task automatic full_sweep();
    for (int s = 0; s < 4; s++) begin
      sweep_pkt(e_cache_mem_tag, 2'(s));
      sweep_pkt(e_cache_mem_stat, 2'(s));
    end
  endtask

  initial begin
    reset_i     = 1'b1;
    req_v_i     = 2'b11;
    mem_ready_i = 1'b1;
    set_req(0, e_cache_mem_data, 2'd0, 2'd0, 3'd0, 1'b0);
    set_req(1, e_cache_mem_data, 2'd0, 2'd0, 3'd0, 1'b0);
    to_next();
    chk_reset_outputs();
    chk_reset_outputs();
    reset_i = 1'b0;

`ifdef BP_BE_DCACHE_INIT_SWEEP_EN
    // Back-to-back sweep with requests pending; init_done on cycle 9.
    full_sweep();
    req_v_i = 2'b00;
    to_neg();
    chk("sweep_done_c9", 32'(init_done_o), 32'd1);
    chk("sweep_done_mem_v", 32'(mem_v_o), 32'd0);
    to_next();

    // Re-sweep with a three-cycle stall on the set 2 tag packet.
    reset_i = 1'b1;
    to_next();
    reset_i = 1'b0;
    sweep_pkt(e_cache_mem_tag, 2'd0);
    sweep_pkt(e_cache_mem_stat, 2'd0);
    sweep_pkt(e_cache_mem_tag, 2'd1);
    sweep_pkt(e_cache_mem_stat, 2'd1);
    mem_ready_i = 1'b0;
    for (int c = 0; c < 3; c++) sweep_pkt(e_cache_mem_tag, 2'd2);
    mem_ready_i = 1'b1;
    sweep_pkt(e_cache_mem_tag, 2'd2);
    sweep_pkt(e_cache_mem_stat, 2'd2);
    sweep_pkt(e_cache_mem_tag, 2'd3);
    sweep_pkt(e_cache_mem_stat, 2'd3);
    to_neg();
    chk("stall_sweep_done", 32'(init_done_o), 32'd1);
    to_next();

    // Reset pulsed at set 1 restarts the sweep from set 0.
    reset_i = 1'b1;
    to_next();
    reset_i = 1'b0;
    sweep_pkt(e_cache_mem_tag, 2'd0);
    sweep_pkt(e_cache_mem_stat, 2'd0);
    reset_i = 1'b1;
    chk_reset_outputs();
    reset_i = 1'b0;
    full_sweep();
`else
    // No sweep: ready on the first cycle; request accepted when mem_ready_i rises.
    req_v_i     = 2'b01;
    mem_ready_i = 1'b0;
    set_req(0, e_cache_mem_data, e_cache_data_mem_write, 2'd2, 3'd3, 1'b0);
    to_neg();
    chk("nosweep_init_done", 32'(init_done_o), 32'd1);
    chk("nosweep_mem_v", 32'(mem_v_o), 32'd1);
    chk("nosweep_stall_yumi", 32'(req_yumi_o), 32'd0);
    chk("nosweep_index", 32'(mem_index_o), 32'd2);
    to_next();
    mem_ready_i = 1'b1;
    to_neg();
    chk("nosweep_yumi", 32'(req_yumi_o), 32'b01);
    chk("nosweep_opcode", 32'(mem_opcode_o), 32'(e_cache_data_mem_write));
    to_next();
    req_v_i = 2'b10;
    to_neg();
    chk("nosweep_r1_yumi", 32'(req_yumi_o), 32'b10);
    to_next();
`endif

    // Pointer now favours requester 0. Stalled grant to requester 1 must persist.
    set_req(0, e_cache_mem_data, e_cache_data_mem_read, 2'd1, 3'd5, 1'b0);
    set_req(1, e_cache_mem_tag, e_cache_tag_mem_set_tag, 2'd3, 3'd6, 1'b0);
    req_v_i     = 2'b10;
    mem_ready_i = 1'b0;
    to_neg();
    chk("hold_mem_v", 32'(mem_v_o), 32'd1);
    chk("hold_kind", 32'(mem_kind_o), 32'(e_cache_mem_tag));
    chk("hold_way", 32'(mem_way_o), 32'd6);
    chk("hold_yumi0", 32'(req_yumi_o), 32'd0);
    to_next();
    req_v_i = 2'b11;
    to_neg();
    chk("hold_keep_kind", 32'(mem_kind_o), 32'(e_cache_mem_tag));
    chk("hold_keep_index", 32'(mem_index_o), 32'd3);
    chk("hold_yumi1", 32'(req_yumi_o), 32'd0);
    to_next();
    mem_ready_i = 1'b1;
    to_neg();
    chk("hold_release_yumi", 32'(req_yumi_o), 32'b10);
    to_next();

    // Both valid continuously: grants alternate starting with requester 0.
    for (int c = 0; c < 4; c++) begin
      to_neg();
      chk("rr_yumi", 32'(req_yumi_o), (c % 2 == 0) ? 32'b01 : 32'b10);
      chk("rr_way", 32'(mem_way_o), (c % 2 == 0) ? 32'd5 : 32'd6);
      to_next();
    end

    // Point at requester 1, then run a locked burst with requester 0 waiting.
    req_v_i = 2'b01;
    to_neg();
    chk("pre_lock_yumi", 32'(req_yumi_o), 32'b01);
    to_next();
    req_v_i = 2'b11;
    set_req(1, e_cache_mem_data, e_cache_data_mem_read, 2'd2, 3'd1, 1'b1);
    to_neg();
    chk("lock_first_yumi", 32'(req_yumi_o), 32'b10);
    chk("lock_first_kind", 32'(mem_kind_o), 32'(e_cache_mem_data));
    to_next();
    to_neg();
    chk("lock_beat1_yumi", 32'(req_yumi_o), 32'b10);
    to_next();
    req_v_i = 2'b01;
    to_neg();
    chk("lock_gap_yumi", 32'(req_yumi_o), 32'd0);
    chk("lock_gap_mem_v", 32'(mem_v_o), 32'd0);
    to_next();
    req_v_i = 2'b11;
    to_neg();
    chk("lock_beat2_yumi", 32'(req_yumi_o), 32'b10);
    to_next();
    set_req(1, e_cache_mem_stat, e_cache_stat_mem_clear_dirty, 2'd2, 3'd1, 1'b0);
    to_neg();
    chk("unlock_yumi", 32'(req_yumi_o), 32'b10);
    chk("unlock_kind", 32'(mem_kind_o), 32'(e_cache_mem_stat));
    chk("unlock_opcode", 32'(mem_opcode_o), 32'(e_cache_stat_mem_clear_dirty));
    to_next();
    req_v_i = 2'b01;
    to_neg();
    chk("after_lock_r0_yumi", 32'(req_yumi_o), 32'b01);
    chk("after_lock_index", 32'(mem_index_o), 32'd1);
    to_next();

    // Reset again with both requesting.
    req_v_i = 2'b11;
    reset_i = 1'b1;
    to_next();
    chk_reset_outputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_be_dcache_lce_mem_arbiter.md
BP_BE_DCACHE_LCE_MEM_ARBITER -- requirements
Module: bp_be_dcache_lce_mem_arbiter

Interface
REQ-001 SHALL have parameter sets_p, default 64, number of dcache sets; index_width = log2(sets_p).
REQ-002 SHALL have parameter ways_p, default 8, number of ways; way_width = log2(ways_p).
REQ-003 SHALL have port clk_i  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset_i  in  1  synchronous, active-high reset.
REQ-005 SHALL have port req_v_i  in  2  per-requester valid; bit 0 = LCE cmd handler, bit 1 = LCE data-cmd handler.
REQ-006 SHALL have port req_kind_i  in  2x2  target memory per requester (bp_cache_mem_kind_e).
REQ-007 SHALL have port req_opcode_i  in  2x2  opcode per requester, data/tag/stat opcode enum per kind.
REQ-008 SHALL have port req_index_i  in  2 x index_width  set index per requester.
REQ-009 SHALL have port req_way_i  in  2 x way_width  way per requester.
REQ-010 SHALL have port req_lock_i  in  2  hold grant after this beat.
REQ-011 SHALL have port req_yumi_o  out  2  per-requester accept, at most one bit set.
REQ-012 SHALL have ports mem_v_o (out 1), mem_kind_o (out 2), mem_opcode_o (out 2), mem_index_o (out index_width), mem_way_o (out way_width): packet to dcache memories.
REQ-013 SHALL have port mem_ready_i  in  1  dcache accepts packet this cycle.
REQ-014 SHALL have port init_done_o  out  1  sweep complete, requests serviceable.

Function
REQ-015 SHALL implement states e_sweep_tag, e_sweep_stat, e_ready, e_locked.
REQ-016 Sweep: SHALL emit, for s = 0..sets_p-1, tag packet (kind tag, e_cache_tag_mem_set_clear, index s, way 0), then stat packet (kind stat, e_cache_stat_mem_set_clear, index s, way 0).
REQ-017 Sweep SHALL advance only on mem_v_o & mem_ready_i; set counter SHALL increment after each accepted stat packet.
REQ-018 Accept of stat packet with s = sets_p-1 SHALL move to e_ready; init_done_o SHALL be 1 from the next cycle; counter SHALL NOT wrap.
REQ-019 During sweep req_yumi_o SHALL be 0 regardless of req_v_i.
REQ-020 e_ready: SHALL select among valid requesters round-robin; on tie, the requester not granted last wins.
REQ-021 mem_* SHALL be a combinational copy of the selected request (zero latency); mem_v_o = OR of req_v_i in e_ready.
REQ-022 req_yumi_o[i] SHALL equal selected(i) & req_v_i[i] & mem_ready_i.
REQ-023 Round-robin pointer SHALL update only on a yumi, pointing away from the requester just accepted.
REQ-024 Accept with req_lock_i=1 SHALL enter e_locked owned by that requester.
REQ-025 e_locked: only owner SHALL be selectable; other requester's valid SHALL be ignored.
REQ-026 e_locked: owner accept with req_lock_i=0 SHALL return to e_ready; with req_lock_i=1 SHALL stay.
REQ-027 Requester SHALL hold kind/opcode/index/way stable while valid and not yumi'd; arbiter SHALL NOT switch selection in that case.
REQ-028 Kind value 2'b11 SHALL be illegal; simulation assertion SHALL fire; no other behaviour defined.

Reset
REQ-029 reset_i high SHALL force: state e_sweep_tag (macro defined) or e_ready (undefined), set counter 0, pointer favouring requester 0, lock cleared.
REQ-030 While reset_i high: mem_v_o=0, req_yumi_o=0, init_done_o=0.
REQ-031 Reset asserted mid-sweep or mid-lock SHALL abandon operation; sweep restarts at set 0 after release.

Configuration
REQ-032 Macro BP_BE_DCACHE_INIT_SWEEP_EN defined: REQ-016..019 sweep SHALL be compiled in.
REQ-033 Macro undefined: sweep states and counter SHALL be absent; init_done_o=1 from first cycle after reset release; arbitration identical.

Structure
REQ-034 bp_cache_mem_kind_e (e_cache_mem_data=0, e_cache_mem_tag=1, e_cache_mem_stat=2) and arbiter state enum SHALL live in bp_be_dcache_pkg alongside existing mem opcode enums.
REQ-035 Round-robin selection SHALL be one sub-module, bp_be_dcache_rr_arb_2, inputs valid[2] + pointer, output one-hot select.

Verification
REQ-036 sets_p=4, macro on, mem_ready_i=1: 8 packets tag/stat set_clear for indices 0,0,1,1,2,2,3,3; init_done_o rises cycle 9.
REQ-037 Sweep with mem_ready_i low 3 cycles on set 2 tag packet: packet held stable, sequence resumes unchanged.
REQ-038 e_ready, both valid continuously, ready=1: yumi alternates 01,10,01,10.
REQ-039 Requester 1 data-mem read lock=1, then 2 beats lock=1, then stat clear_dirty lock=0, requester 0 valid throughout: requester 0 yumi only after the lock=0 beat.
REQ-040 reset_i pulsed at sweep set 1: next post-reset packet is tag set_clear index 0; init_done_o stays 0.
REQ-041 Macro off: init_done_o=1 first cycle after reset; single request from requester 0 yumi'd same cycle as mem_ready_i.
